// File: rtl/mouse_script_gen.sv
// mouse_script_gen: scripted mouse-event source standing in for mouse_ctl.
// On a start command it walks the cursor toward a clamped target at a fixed
// tick rate, optionally issues a timed click followed by a release gap, then
// pulses done and returns to idle. Cursor position persists across commands.
`timescale 1ns/1ps

module mouse_script_gen #(
  parameter int XW        = 12,
  parameter int TICK_DIV  = 1000,
  parameter int STEP      = 1,
  parameter int CLICK_LEN = 4,
  parameter int X_MAX     = 799,
  parameter int Y_MAX     = 599
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] tgt_x,
  input  logic [XW-1:0] tgt_y,
  input  logic          click_en,
  input  logic          btn_sel,
  output logic [XW-1:0] mouse_xpos,
  output logic [XW-1:0] mouse_ypos,
  output logic          mouse_left,
  output logic          mouse_right,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MOVE  = 3'd1,
    S_PRESS = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (CLICK_LEN > 1) ? $clog2(CLICK_LEN) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CLICK_LAST = CW'(CLICK_LEN - 1);
  localparam logic [XW-1:0] XMAX_C     = XW'(X_MAX);
  localparam logic [XW-1:0] YMAX_C     = XW'(Y_MAX);
  // One bit wider than the coordinates so a large STEP still compares correctly.
  localparam logic [XW:0]   STEP_C     = (XW + 1)'(STEP);

  // Saturate a requested coordinate to the screen limit.
  function automatic logic [XW-1:0] sat_coord(input logic [XW-1:0] v,
                                               input logic [XW-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Move pos toward tgt by at most STEP; the distance is taken before the
  // update, so the result can never pass the target or wrap.
  function automatic logic [XW-1:0] step_toward(input logic [XW-1:0] pos,
                                                 input logic [XW-1:0] tgt);
    logic [XW-1:0] diff;
    logic [XW-1:0] amt;
    diff = (tgt >= pos) ? (tgt - pos) : (pos - tgt);
    amt  = ({1'b0, diff} > STEP_C) ? STEP_C[XW-1:0] : diff;
    return (tgt >= pos) ? (pos + amt) : (pos - amt);
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q,  tick_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [XW-1:0] tx_q,    tx_d;
  logic [XW-1:0] ty_q,    ty_d;
  logic          click_q, click_d;
  logic          sel_q,   sel_d;
  logic [XW-1:0] xpos_q,  xpos_d;
  logic [XW-1:0] ypos_q,  ypos_d;
  logic          left_q,  left_d;
  logic          right_q, right_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic at_target;
  assign at_target = (xpos_q == tx_q) && (ypos_q == ty_q);

  // Next-state, datapath update and look-ahead of the registered outputs.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    click_d = click_q;
    sel_d   = sel_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_d    = sat_coord(tgt_x, XMAX_C);
          ty_d    = sat_coord(tgt_y, YMAX_C);
          click_d = click_en;
          sel_d   = btn_sel;
          tick_d  = '0;
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        if (at_target) begin
          cnt_d   = '0;
          state_d = click_q ? S_PRESS : S_DONE;
        end else if (tick_q == TICK_LAST) begin
          xpos_d = step_toward(xpos_q, tx_q);
          ypos_d = step_toward(ypos_q, ty_q);
          tick_d = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_PRESS: begin
        if (cnt_q == CLICK_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == CLICK_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    left_d  = (state_d == S_PRESS) && !sel_d;
    right_d = (state_d == S_PRESS) &&  sel_d;
  end

  // Control state and all outputs; reset aborts any command and releases buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      cnt_q   <= '0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      left_q  <= left_d;
      right_q <= right_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Latched command fields; only meaningful once a start has been accepted.
  always_ff @(posedge clk) begin
    tx_q    <= tx_d;
    ty_q    <= ty_d;
    click_q <= click_d;
    sel_q   <= sel_d;
  end

  assign mouse_xpos  = xpos_q;
  assign mouse_ypos  = ypos_q;
  assign mouse_left  = left_q;
  assign mouse_right = right_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mouse_script_gen.sv
// Bench for mouse_script_gen: three instances with different tick/step
// settings, directed scenarios followed by randomized commands, each cycle
// compared against a timeline model built from the command's step list.
`timescale 1ns/1ps

module tb_mouse_script_gen;

  localparam int CL   = 4;
  localparam int XMAX = 799;
  localparam int YMAX = 599;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        start [3];
  logic [11:0] tgx   [3];
  logic [11:0] tgy   [3];
  logic        cen   [3];
  logic        bsel  [3];
  logic [11:0] xo    [3];
  logic [11:0] yo    [3];
  logic        lo    [3];
  logic        ro    [3];
  logic        bo    [3];
  logic        dn    [3];

  int n_chk  = 0;
  int n_fail = 0;
  int mx [3];
  int my [3];

  always #5 clk = ~clk;

  mouse_script_gen #(.XW(12), .TICK_DIV(4), .STEP(1), .CLICK_LEN(CL),
                     .X_MAX(XMAX), .Y_MAX(YMAX)) dut_a (
    .clk(clk), .rst(rst[0]), .start(start[0]), .tgt_x(tgx[0]), .tgt_y(tgy[0]),
    .click_en(cen[0]), .btn_sel(bsel[0]), .mouse_xpos(xo[0]), .mouse_ypos(yo[0]),
    .mouse_left(lo[0]), .mouse_right(ro[0]), .busy(bo[0]), .done(dn[0]));

  mouse_script_gen #(.XW(12), .TICK_DIV(4), .STEP(3), .CLICK_LEN(CL),
                     .X_MAX(XMAX), .Y_MAX(YMAX)) dut_b (
    .clk(clk), .rst(rst[1]), .start(start[1]), .tgt_x(tgx[1]), .tgt_y(tgy[1]),
    .click_en(cen[1]), .btn_sel(bsel[1]), .mouse_xpos(xo[1]), .mouse_ypos(yo[1]),
    .mouse_left(lo[1]), .mouse_right(ro[1]), .busy(bo[1]), .done(dn[1]));

  mouse_script_gen #(.XW(12), .TICK_DIV(1), .STEP(200), .CLICK_LEN(CL),
                     .X_MAX(XMAX), .Y_MAX(YMAX)) dut_c (
    .clk(clk), .rst(rst[2]), .start(start[2]), .tgt_x(tgx[2]), .tgt_y(tgy[2]),
    .click_en(cen[2]), .btn_sel(bsel[2]), .mouse_xpos(xo[2]), .mouse_ypos(yo[2]),
    .mouse_left(lo[2]), .mouse_right(ro[2]), .busy(bo[2]), .done(dn[2]));

  function automatic int p_td(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int p_st(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 200;
    endcase
  endfunction

  function automatic logic [63:0] status(input int i);
    return {36'd0, xo[i], yo[i], lo[i], ro[i], bo[i], dn[i]};
  endfunction

  function automatic int step_ref(input int p, input int t, input int s);
    if (p < t) return p + (((t - p) < s) ? (t - p) : s);
    else       return p - (((p - t) < s) ? (p - t) : s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one command on instance i and check every cycle until one cycle past done.
  // spam: re-assert start mid-move and in the done cycle with a different target.
  // abort_off > 0: assert reset abort_off cycles after the final position is reached.
  task automatic run_cmd(input int i, input int tx, input int ty, input bit ce,
                         input bit bs, input bit spam, input int abort_off);
    int cx, cy, px, py, kk, t, l, d, k, ab;
    int qx[$];
    int qy[$];
    logic [63:0] ex;
    bit press;
    cx = (tx > XMAX) ? XMAX : tx;
    cy = (ty > YMAX) ? YMAX : ty;
    px = mx[i];
    py = my[i];
    qx.push_back(px);
    qy.push_back(py);
    while (px != cx || py != cy) begin
      px = step_ref(px, cx, p_st(i));
      py = step_ref(py, cy, p_st(i));
      qx.push_back(px);
      qy.push_back(py);
    end
    kk = qx.size() - 1;
    t  = p_td(i);
    l  = 1 + kk * t;
    d  = ce ? (l + 2 * CL + 1) : (l + 1);
    ab = (abort_off > 0) ? (l + abort_off) : -1;

    start[i] = 1'b1;
    tgx[i]   = 12'(tx);
    tgy[i]   = 12'(ty);
    cen[i]   = ce;
    bsel[i]  = bs;
    @(negedge clk);
    start[i] = 1'b0;
    tgx[i]   = 12'($urandom_range(4095));
    tgy[i]   = 12'($urandom_range(4095));
    cen[i]   = ~ce;
    bsel[i]  = ~bs;

    for (int c = 1; c <= d + 1; c++) begin
      k = (c - 1) / t;
      if (k > kk) k = kk;
      press = ce && (c >= l + 1) && (c <= l + CL);
      ex = {36'd0, 12'(qx[k]), 12'(qy[k]), press && !bs, press && bs, c <= d, c == d};
      chk($sformatf("inst%0d cyc%0d", i, c), status(i), ex);
      if (c == ab) begin
        rst[i] = 1'b1;
        @(negedge clk);
        rst[i] = 1'b0;
        chk($sformatf("inst%0d after abort", i), status(i), 64'd0);
        mx[i] = 0;
        my[i] = 0;
        return;
      end
      start[i] = spam && ((c == 2 && l >= 3) || c == d);
      if (c <= d) @(negedge clk);
    end
    start[i] = 1'b0;
    mx[i] = cx;
    my[i] = cy;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx, ty;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; tgx[i] = '0; tgy[i] = '0;
      cen[i] = 1'b0; bsel[i] = 1'b0; mx[i] = 0; my[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Idle after reset with start held low.
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk($sformatf("idle inst%0d", i), status(i), 64'd0);
    end

    // Instance A: basic move with left click, busy-start rejection, abort in press.
    run_cmd(0, 10, 10, 1'b1, 1'b0, 1'b0, 0);
    run_cmd(0, 3, 7, 1'b0, 1'b0, 1'b1, 0);
    run_cmd(0, 12, 12, 1'b1, 1'b1, 1'b1, 2);
    run_cmd(0, 5, 5, 1'b1, 1'b0, 1'b0, 0);
    run_cmd(0, 5, 5, 1'b0, 1'b0, 1'b0, 0);
    run_cmd(0, 5, 5, 1'b1, 1'b1, 1'b0, 0);

    // Instance B: STEP=3 diagonal imbalance, no overshoot.
    run_cmd(1, 10, 10, 1'b0, 1'b0, 1'b0, 0);
    run_cmd(1, 20, 11, 1'b0, 1'b0, 1'b0, 0);
    run_cmd(1, 2, 30, 1'b1, 1'b1, 1'b0, 0);

    // Instance C: clamping with a large step.
    run_cmd(2, 4095, 4095, 1'b0, 1'b0, 1'b0, 0);
    run_cmd(2, 0, 4095, 1'b1, 1'b0, 1'b0, 0);
    run_cmd(2, 800, 600, 1'b0, 1'b0, 1'b1, 0);

    // Randomized commands.
    for (int n = 0; n < 15; n++) begin
      tx = mx[0] + int'($urandom_range(20)) - 10;
      ty = my[0] + int'($urandom_range(20)) - 10;
      if (tx < 0) tx = 0;
      if (ty < 0) ty = 0;
      run_cmd(0, tx, ty, 1'($urandom_range(1)), 1'($urandom_range(1)),
              1'($urandom_range(1)), 0);
    end
    for (int n = 0; n < 10; n++) begin
      tx = mx[1] + int'($urandom_range(40)) - 20;
      ty = my[1] + int'($urandom_range(40)) - 20;
      if (tx < 0) tx = 0;
      if (ty < 0) ty = 0;
      run_cmd(1, tx, ty, 1'($urandom_range(1)), 1'($urandom_range(1)),
              1'($urandom_range(1)), 0);
    end
    for (int n = 0; n < 20; n++) begin
      run_cmd(2, int'($urandom_range(4095)), int'($urandom_range(4095)),
              1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
